// File: rtl/npc_predict.sv
// npc_predict -- next-PC generator for the IF stage.
//
// The next fetch PC is predicted from a direct-mapped branch target buffer
// (BTB) with 2-bit saturating direction counters. An optional return-address
// stack (RAS) supplies targets for entries marked as returns. Halt and
// CP0/mispredict redirects always take priority over any prediction.
//
// Build option:
//   NPC_RAS_EN  defined   -> the RAS is built, and is_ret entries predict from
//                            the RAS top when the RAS is non-empty.
//               undefined -> there is no RAS. Call and ret flags are ignored,
//                            is_ret is stored as 0, and every prediction uses
//                            the BTB target.
//
// Parameters:
//   BTB_DEPTH  BTB entries (power of two, 2..256)
//   RAS_DEPTH  RAS entries (power of two, 2..16), used only with NPC_RAS_EN
//   HALT_ADDR  PC at which fetch holds
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   pc                         current fetch PC (word-aligned)
//   redirect, redirect_pc      redirect request and its target
//   upd_valid                  resolved control-transfer update this cycle
//   upd_slot_pc                delay-slot address, used as the BTB key
//   upd_taken, upd_target      resolved direction and target
//   upd_is_call, upd_is_ret    call (push slot+4) and return (pop) markers
//   npc                        next fetch PC (combinational)
//   pred_hit                   BTB tag hit on pc
//   pred_taken                 npc came from a BTB/RAS prediction
module npc_predict #(
  parameter int          BTB_DEPTH = 16,
  parameter int          RAS_DEPTH = 4,
  parameter logic [31:0] HALT_ADDR = 32'h0000_417c
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_slot_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_is_call,
  input  logic        upd_is_ret,
  output logic [31:0] npc,
  output logic        pred_hit,
  output logic        pred_taken
);

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = 30 - IDX;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // BTB storage. Only valid/ctr/is_ret are reset; tag and target are
  // meaningless while valid is clear.
  logic             valid_q [BTB_DEPTH];
  logic             valid_d [BTB_DEPTH];
  logic [TAG_W-1:0] tag_q   [BTB_DEPTH];
  logic [TAG_W-1:0] tag_d   [BTB_DEPTH];
  logic [29:0]      tgt_q   [BTB_DEPTH];
  logic [29:0]      tgt_d   [BTB_DEPTH];
  logic [1:0]       ctr_q   [BTB_DEPTH];
  logic [1:0]       ctr_d   [BTB_DEPTH];
  logic             ret_q   [BTB_DEPTH];
  logic             ret_d   [BTB_DEPTH];

  logic [IDX-1:0]   l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, l_pred, u_hit;
  logic             is_ret_eff;
  logic             ras_nonempty;
  logic [31:0]      ras_top;

  assign l_idx = pc[IDX+1:2];
  assign l_tag = pc[31:IDX+2];
  assign u_idx = upd_slot_pc[IDX+1:2];
  assign u_tag = upd_slot_pc[31:IDX+2];

  // Lookup reads the registered state only, so a same-cycle update to the
  // same index is not bypassed.
  assign l_hit  = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign l_pred = l_hit && ctr_q[l_idx][1];
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

`ifdef NPC_RAS_EN
  localparam int            PW       = $clog2(RAS_DEPTH);
  localparam logic [PW:0]   RAS_FULL = (PW+1)'(RAS_DEPTH);

  // Circular stack: ras_ptr_q is the next free slot, the top is one below.
  logic [31:0]   ras_q [RAS_DEPTH];
  logic [31:0]   ras_d [RAS_DEPTH];
  logic [PW-1:0] ras_ptr_q, ras_ptr_d, ras_top_idx;
  logic [PW:0]   ras_cnt_q, ras_cnt_d;

  assign is_ret_eff   = upd_is_ret;
  assign ras_nonempty = (ras_cnt_q != '0);
  assign ras_top_idx  = ras_ptr_q - PW'(1);
  assign ras_top      = ras_q[ras_top_idx];

  // Pop first, then push, so call+ret together replaces the top. A push
  // onto a full stack overwrites the oldest entry and the count saturates.
  always_comb begin
    ras_d     = ras_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (upd_valid) begin
      if (upd_is_ret && (ras_cnt_d != '0)) begin
        ras_ptr_d = ras_ptr_d - PW'(1);
        ras_cnt_d = ras_cnt_d - (PW+1)'(1);
      end
      if (upd_is_call) begin
        ras_d[ras_ptr_d] = upd_slot_pc + 32'd4;
        ras_ptr_d        = ras_ptr_d + PW'(1);
        if (ras_cnt_d != RAS_FULL) ras_cnt_d = ras_cnt_d + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end
`else
  logic unused_ras;
  assign unused_ras   = upd_is_call ^ upd_is_ret;
  assign is_ret_eff   = 1'b0;
  assign ras_nonempty = 1'b0;
  assign ras_top      = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{pc[1:0], upd_slot_pc[1:0], upd_target[1:0]};

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    ret_d   = ret_q;
    if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          ctr_d[u_idx] = sat_inc(ctr_q[u_idx]);
          tgt_d[u_idx] = upd_target[31:2];
          ret_d[u_idx] = is_ret_eff;
        end else begin
          ctr_d[u_idx] = sat_dec(ctr_q[u_idx]);
        end
      end else if (upd_taken) begin
        // A taken miss replaces whatever occupies the index, weakly taken.
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = upd_target[31:2];
        ctr_d[u_idx]   = 2'b10;
        ret_d[u_idx]   = is_ret_eff;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
        ret_q[i]   <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      ret_q   <= ret_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

  always_comb begin
    npc        = pc + 32'd4;
    pred_taken = 1'b0;
    if (pc == HALT_ADDR) begin
      npc = pc;
    end else if (redirect) begin
      npc = redirect_pc;
    end else if (l_pred) begin
      pred_taken = 1'b1;
      if (ret_q[l_idx] && ras_nonempty) npc = ras_top;
      else                              npc = {tgt_q[l_idx], 2'b00};
    end
  end

  assign pred_hit = l_hit;

endmodule
